// File: rtl/ysyx_23060096_exu_issue.sv
// Execute-issue stage: buffers operand-resolved micro-ops, drives the ALU from the head entry
// and registers the result toward the WBU. Optional same-cycle bypass: YSYX_23060096_EXU_BYPASS_EN.
module ysyx_23060096_exu_issue #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_src1_sel,
   input  logic [1:0]      in_src2_sel,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic [3:0]      in_alu_op,
   input  logic [4:0]      in_rd,
   input  logic            in_wen,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_op,
   input  logic [XLEN-1:0] alu_out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd,
   output logic            out_wen
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] fifo_a   [DEPTH];
   logic [XLEN-1:0] fifo_b   [DEPTH];
   logic [3:0]      fifo_op  [DEPTH];
   logic [4:0]      fifo_rd  [DEPTH];
   logic            fifo_wen [DEPTH];

   logic [CW-1:0]   count;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;

   logic [XLEN-1:0] mux_a;
   logic [XLEN-1:0] mux_b;
   logic [4:0]      sel_rd;
   logic            sel_wen;
   logic            bypass;
   logic            can_capture;
   logic            push;
   logic            push_fifo;
   logic            pop;
   logic            capture;

   // Operands are resolved on the way in so the IDU may change its fields right after the handshake.
   assign mux_a = in_src1_sel ? in_pc : in_rs1_data;

   always_comb begin
      mux_b = '0;
      unique case (in_src2_sel)
         2'b00:   mux_b = in_rs2_data;
         2'b01:   mux_b = in_imm;
         2'b10:   mux_b = XLEN'(4);
         default: mux_b = '0;
      endcase
   end

`ifdef YSYX_23060096_EXU_BYPASS_EN
   assign bypass = (count == '0) && in_valid;
`else
   assign bypass = 1'b0;
`endif

   assign in_ready    = (count != CW'(DEPTH));
   assign can_capture = !out_valid || out_ready;
   assign push        = in_valid && in_ready;
   assign pop         = (count != '0) && can_capture;
   assign push_fifo   = push && !(bypass && can_capture);
   assign capture     = pop || (bypass && can_capture);

   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_op  = '0;
      sel_rd  = '0;
      sel_wen = 1'b0;
      if (count != '0) begin
         alu_a   = fifo_a[rd_ptr];
         alu_b   = fifo_b[rd_ptr];
         alu_op  = fifo_op[rd_ptr];
         sel_rd  = fifo_rd[rd_ptr];
         sel_wen = fifo_wen[rd_ptr];
      end else if (bypass) begin
         alu_a   = mux_a;
         alu_b   = mux_b;
         alu_op  = in_alu_op;
         sel_rd  = in_rd;
         sel_wen = in_wen;
      end
   end

   // Storage needs no reset: entries are only read while count says they are live.
   always_ff @(posedge clk) begin
      if (push_fifo) begin
         fifo_a[wr_ptr]   <= mux_a;
         fifo_b[wr_ptr]   <= mux_b;
         fifo_op[wr_ptr]  <= in_alu_op;
         fifo_rd[wr_ptr]  <= in_rd;
         fifo_wen[wr_ptr] <= in_wen;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_rd     <= '0;
         out_wen    <= 1'b0;
      end else begin
         if (push_fifo) wr_ptr <= wr_ptr + 1'b1;
         if (pop)       rd_ptr <= rd_ptr + 1'b1;
         case ({push_fifo, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // x0 is never written, so its write enable is squashed here rather than in the WBU.
         if (capture) begin
            out_valid  <= 1'b1;
            out_result <= alu_out;
            out_rd     <= sel_rd;
            out_wen    <= sel_wen && (sel_rd != 5'd0);
         end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule
